maxnet_weight_bank: RTL

Parametrised weight store for the Maxnet network: holds the self-excitation weight (diagonal) and the lateral-inhibition weight (−ε, off-diagonal) for an N-channel network. Rows of the N×N weight matrix are streamed to the neuron datapath one IEEE-754 single-precision word per cycle over a valid/ready handshake. Weights are runtime-reconfigurable without disturbing a row already in flight.

---
 rtl/maxnet_weight_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/maxnet_weight_bank.sv
// maxnet_weight_bank: weight store for an N-channel Maxnet network.
// Streams row `req_row` of the N x N weight matrix, one word per cycle.
// The diagonal word is the self-excitation weight. Every other word is the
// lateral-inhibition weight.
//
// Optional feature macro: MAXNET_WBANK_CFG_EN
//   When it is defined, cfg_we/cfg_sel/cfg_data write the live weights at runtime.
//   When it is undefined, the weights are fixed at DIAG_INIT/OFF_INIT.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cfg_we/sel/data      live weight write, sel 0 = diag, 1 = off (CFG_EN only)
//   req_valid/ready/row  row request handshake
//   req_err              one-cycle pulse after a request with req_row >= N
//   w_valid/ready        weight word handshake
//   w_data/col/last      weight W[row][col], its column, final-column flag
module maxnet_weight_bank #(
   parameter int unsigned     N         = 4,
   parameter int unsigned     DW        = 32,
   parameter logic [DW-1:0]   DIAG_INIT = 32'h3F800000,
   parameter logic [DW-1:0]   OFF_INIT  = 32'hBE4CCCCD,
   localparam int unsigned    RW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef MAXNET_WBANK_CFG_EN
   input  logic          cfg_we,
   input  logic          cfg_sel,
   input  logic [DW-1:0] cfg_data,
`endif
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [RW-1:0] req_row,
   output logic          req_err,
   output logic          w_valid,
   input  logic          w_ready,
   output logic [DW-1:0] w_data,
   output logic [RW-1:0] w_col,
   output logic          w_last
);

   typedef enum logic [0:0] {IDLE, STREAM} state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] row_q, row_d, col_q, col_d, col_nxt;
   logic [DW-1:0] diag_s_q, diag_s_d, off_s_q, off_s_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic          req_ready_q, req_ready_d;
   logic          req_err_q, req_err_d;
   logic          w_valid_q, w_valid_d;
   logic          w_last_q, w_last_d;
   logic [DW-1:0] diag_live, off_live;

`ifdef MAXNET_WBANK_CFG_EN
   logic [DW-1:0] diag_r_q, diag_r_d, off_r_q, off_r_d;

   // Live weight write path. It is independent of the streaming state.
   always_comb begin
      diag_r_d = diag_r_q;
      off_r_d  = off_r_q;
      if (cfg_we) begin
         if (cfg_sel) off_r_d  = cfg_data;
         else         diag_r_d = cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         diag_r_q <= DIAG_INIT;
         off_r_q  <= OFF_INIT;
      end else begin
         diag_r_q <= diag_r_d;
         off_r_q  <= off_r_d;
      end
   end

   assign diag_live = diag_r_q;
   assign off_live  = off_r_q;
`else
   assign diag_live = DIAG_INIT;
   assign off_live  = OFF_INIT;
`endif

   assign col_nxt = col_q + RW'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      diag_s_d    = diag_s_q;
      off_s_d     = off_s_q;
      w_data_d    = w_data_q;
      req_ready_d = req_ready_q;
      req_err_d   = 1'b0;
      w_valid_d   = w_valid_q;
      w_last_d    = w_last_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (32'(req_row) < N) begin
                  // Snapshot the live (pre-write) weights so a later cfg write cannot alter this row.
                  state_d     = STREAM;
                  row_d       = req_row;
                  col_d       = '0;
                  diag_s_d    = diag_live;
                  off_s_d     = off_live;
                  w_data_d    = (req_row == '0) ? diag_live : off_live;
                  w_valid_d   = 1'b1;
                  w_last_d    = 1'b0;
                  req_ready_d = 1'b0;
               end else begin
                  req_err_d   = 1'b1;
               end
            end
         end
         STREAM: begin
            if (w_ready) begin
               if (w_last_q) begin
                  state_d     = IDLE;
                  col_d       = '0;
                  w_data_d    = '0;
                  w_valid_d   = 1'b0;
                  w_last_d    = 1'b0;
                  req_ready_d = 1'b1;
               end else begin
                  col_d       = col_nxt;
                  w_data_d    = (col_nxt == row_q) ? diag_s_q : off_s_q;
                  w_last_d    = (col_nxt == RW'(N - 1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         diag_s_q    <= DIAG_INIT;
         off_s_q     <= OFF_INIT;
         w_data_q    <= '0;
         req_ready_q <= 1'b1;
         req_err_q   <= 1'b0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         diag_s_q    <= diag_s_d;
         off_s_q     <= off_s_d;
         w_data_q    <= w_data_d;
         req_ready_q <= req_ready_d;
         req_err_q   <= req_err_d;
         w_valid_q   <= w_valid_d;
         w_last_q    <= w_last_d;
      end
   end

   assign req_ready = req_ready_q;
   assign req_err   = req_err_q;
   assign w_valid   = w_valid_q;
   assign w_data    = w_data_q;
   assign w_col     = col_q;
   assign w_last    = w_last_q;

endmodule
